// File: rtl/ysyx_24090003_ifu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24090003_ifu_pkg
//  Description : Shared types and defaults for the prefetching instruction
//                fetch unit (state encoding, prefetch queue entry layout).
//  Revision    : 1.0 - initial release
// ============================================================================
package ysyx_24090003_ifu_pkg;

   localparam int              c_XLEN     = 32;
   localparam logic [31:0]     c_RESET_PC = 32'h8000_0000;

   // FETCH issues requests; HALT stops issuing after an access fault.
   typedef enum logic [0:0] {
      FETCH = 1'b0,
      HALT  = 1'b1
   } ifu_state_e;

   // One prefetch queue slot: the fetched word tagged with its address.
   typedef struct packed {
      logic [c_XLEN-1:0] pc;
      logic [c_XLEN-1:0] inst;
      logic              err;
   } ifu_entry_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_24090003_ifu_prefetch_if.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24090003_ifu_prefetch_if
//  Description : Instruction memory bus: valid/ready request channel plus an
//                always-accepted in-order response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ysyx_24090003_ifu_prefetch_if #(
   parameter int XLEN = 32
);
   logic            o_mem_req_valid;
   logic            i_mem_req_ready;
   logic [XLEN-1:0] o_mem_req_addr;
   logic            i_mem_rsp_valid;
   logic [XLEN-1:0] i_mem_rsp_data;
   logic            i_mem_rsp_err;

   // Fetch unit side.
   modport master (
      output o_mem_req_valid,
      output o_mem_req_addr,
      input  i_mem_req_ready,
      input  i_mem_rsp_valid,
      input  i_mem_rsp_data,
      input  i_mem_rsp_err
   );

   // Memory side.
   modport slave (
      input  o_mem_req_valid,
      input  o_mem_req_addr,
      output i_mem_req_ready,
      output i_mem_rsp_valid,
      output i_mem_rsp_data,
      output i_mem_rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/ysyx_24090003_ifu_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24090003_ifu_fifo
//  Description : Synchronous FIFO with flush; push and pop may coincide even
//                when full. DEPTH must be a power of two (>= 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24090003_ifu_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  wire logic                     i_clk,
   input  wire logic                     i_rst,
   input  wire logic                     i_push,
   input  wire logic [WIDTH-1:0]         i_data,
   input  wire logic                     i_pop,
   input  wire logic                     i_flush,
   output      logic [WIDTH-1:0]         o_data,
   output      logic [$clog2(DEPTH):0]   o_count,
   output      logic                     o_full,
   output      logic                     o_empty
);

   localparam int               c_AW      = $clog2(DEPTH);
   localparam logic [c_AW-1:0]  c_PTR_ONE = 1;
   localparam logic [c_AW:0]    c_CNT_ONE = 1;
   localparam logic [c_AW:0]    c_DEPTH   = (c_AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [c_AW-1:0]  r_wr_ptr;
   logic [c_AW-1:0]  r_rd_ptr;
   logic [c_AW:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == c_DEPTH);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop & ~o_empty;
   // A slot freed by a same-cycle pop may be refilled immediately.
   assign w_do_push = i_push & (~o_full | w_do_pop);

   // Storage array: data only, no reset needed since reads are gated by count.
   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush empties the queue in one cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         if (w_do_push && !w_do_pop) begin
            r_count <= r_count + c_CNT_ONE;
         end else if (w_do_pop && !w_do_push) begin
            r_count <= r_count - c_CNT_ONE;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/ysyx_24090003_ifu_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_24090003_ifu_prefetch
//  Description : Multi-cycle prefetching IFU. Issues in-order word fetches
//                with bounded outstanding requests, buffers responses in a
//                prefetch queue and hands them to the IDU. Redirects flush
//                the queue and squash responses still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_24090003_ifu_prefetch
   import ysyx_24090003_ifu_pkg::*;
#(
   parameter int              XLEN            = c_XLEN,
   parameter logic [XLEN-1:0] RESET_PC        = c_RESET_PC,
   parameter int              FIFO_DEPTH      = 4,
   parameter int              MAX_OUTSTANDING = 2
) (
   input  wire logic             i_clk,
   input  wire logic             i_rst,
   input  wire logic             i_redirect_valid,
   input  wire logic [XLEN-1:0]  i_redirect_pc,
   ysyx_24090003_ifu_prefetch_if.master mem,
   output      logic             o_valid,
   input  wire logic             i_ready,
   output      logic [XLEN-1:0]  o_pc,
   output      logic [XLEN-1:0]  o_inst,
   output      logic             o_err
);

   localparam int               c_AW       = $clog2(FIFO_DEPTH);
   localparam logic [c_AW:0]    c_CNT_ONE  = 1;
   localparam logic [c_AW:0]    c_MAX_OS   = (c_AW+1)'(MAX_OUTSTANDING);
   localparam logic [c_AW+1:0]  c_DEPTH_X  = (c_AW+2)'(FIFO_DEPTH);
   localparam logic [XLEN-1:0]  c_PC_STEP  = 4;

   ifu_state_e      r_state;
   logic [XLEN-1:0] r_fetch_pc;     // address of the next new request
   logic [XLEN-1:0] r_rsp_pc;       // address of the next kept response
   logic            r_req_valid;
   logic [XLEN-1:0] r_req_addr;
   logic            r_req_stale;    // held request predates a redirect
   logic [c_AW:0]   r_outstanding;
   logic [c_AW:0]   r_drop_cnt;

   logic            w_req_fire;
   logic            w_rsp_drop;
   logic            w_push;
   logic            w_pop;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   logic [c_AW:0]   w_fifo_count;
   ifu_entry_t      w_push_entry;
   ifu_entry_t      w_head;
   logic [XLEN-1:0] w_redirect_pc;
   logic [XLEN-1:0] w_fetch_pc_nxt;
   logic [c_AW:0]   w_os_nxt;
   logic [c_AW:0]   w_drop_nxt;
   logic [c_AW:0]   w_cnt_nxt;
   logic [c_AW:0]   w_live_nxt;
   logic            w_fetch_nxt;
   logic            w_credit_ok;
   logic            w_issue;

   assign w_redirect_pc = {i_redirect_pc[XLEN-1:2], 2'b00};
   assign w_req_fire    = r_req_valid & mem.i_mem_req_ready;
   assign w_rsp_drop    = mem.i_mem_rsp_valid & (r_drop_cnt != '0);
   assign w_pop         = ~w_fifo_empty & i_ready;
   // A response arriving with a redirect belongs to the abandoned path.
   assign w_push        = mem.i_mem_rsp_valid & ~w_rsp_drop & ~i_redirect_valid
                        & (~w_fifo_full | w_pop);
   assign w_push_entry  = '{pc: r_rsp_pc, inst: mem.i_mem_rsp_data, err: mem.i_mem_rsp_err};

   // Next-cycle bookkeeping used both for state update and the issue decision.
   always_comb begin
      w_os_nxt = r_outstanding;
      if (w_req_fire) begin
         w_os_nxt = w_os_nxt + c_CNT_ONE;
      end
      if (mem.i_mem_rsp_valid) begin
         w_os_nxt = w_os_nxt - c_CNT_ONE;
      end

      w_drop_nxt = r_drop_cnt;
      if (w_rsp_drop) begin
         w_drop_nxt = w_drop_nxt - c_CNT_ONE;
      end
      if (w_req_fire && r_req_stale) begin
         w_drop_nxt = w_drop_nxt + c_CNT_ONE;
      end
      if (i_redirect_valid) begin
         w_drop_nxt = w_os_nxt;
      end

      w_cnt_nxt = w_fifo_count;
      if (w_push) begin
         w_cnt_nxt = w_cnt_nxt + c_CNT_ONE;
      end
      if (w_pop) begin
         w_cnt_nxt = w_cnt_nxt - c_CNT_ONE;
      end
      if (i_redirect_valid) begin
         w_cnt_nxt = '0;
      end

      w_fetch_pc_nxt = r_fetch_pc;
      if (i_redirect_valid) begin
         w_fetch_pc_nxt = w_redirect_pc;
      end else if (w_req_fire && !r_req_stale) begin
         w_fetch_pc_nxt = r_fetch_pc + c_PC_STEP;
      end

      // Every live (non-dropped) request must already own a queue slot.
      w_live_nxt  = w_os_nxt - w_drop_nxt;
      w_credit_ok = ({1'b0, w_cnt_nxt} + {1'b0, w_live_nxt}) < c_DEPTH_X;
      w_fetch_nxt = i_redirect_valid
                  | ((r_state == FETCH) & ~(w_push & mem.i_mem_rsp_err));
      w_issue     = ~i_redirect_valid & w_fetch_nxt & (w_os_nxt < c_MAX_OS)
                  & w_credit_ok & ~(r_req_valid & ~w_req_fire);
   end

   // Fetch control: state, request channel, in-flight and squash counters.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state       <= FETCH;
         r_fetch_pc    <= RESET_PC;
         r_rsp_pc      <= RESET_PC;
         r_req_valid   <= 1'b0;
         r_req_addr    <= '0;
         r_req_stale   <= 1'b0;
         r_outstanding <= '0;
         r_drop_cnt    <= '0;
      end else begin
         case (r_state)
            FETCH: if (!i_redirect_valid && w_push && mem.i_mem_rsp_err) r_state <= HALT;
            HALT:  if (i_redirect_valid) r_state <= FETCH;
            default: r_state <= FETCH;
         endcase

         r_fetch_pc    <= w_fetch_pc_nxt;
         r_outstanding <= w_os_nxt;
         r_drop_cnt    <= w_drop_nxt;

         if (i_redirect_valid) begin
            r_rsp_pc <= w_redirect_pc;
         end else if (w_push) begin
            r_rsp_pc <= r_rsp_pc + c_PC_STEP;
         end

         if (w_issue) begin
            r_req_valid <= 1'b1;
            r_req_addr  <= w_fetch_pc_nxt;
            r_req_stale <= 1'b0;
         end else if (w_req_fire) begin
            r_req_valid <= 1'b0;
            r_req_stale <= 1'b0;
         end else if (i_redirect_valid && r_req_valid) begin
            // Cannot retract a presented request; remember to drop its reply.
            r_req_stale <= 1'b1;
         end
      end
   end

   ysyx_24090003_ifu_fifo #(
      .WIDTH ($bits(ifu_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .i_flush (i_redirect_valid),
      .o_data  (w_head),
      .o_count (w_fifo_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   assign mem.o_mem_req_valid = r_req_valid;
   assign mem.o_mem_req_addr  = r_req_addr;

   assign o_valid = ~w_fifo_empty;
   assign o_pc    = o_valid ? w_head.pc   : '0;
   assign o_inst  = o_valid ? w_head.inst : '0;
   assign o_err   = o_valid & w_head.err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24090003_ifu_prefetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_24090003_ifu_prefetch
//  Description : Directed self-checking bench for the prefetching IFU with a
//                one-cycle-latency instruction memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_24090003_ifu_prefetch;

   localparam logic [31:0] c_RESET_PC = 32'h8000_0000;
   localparam int          c_MAX_OS   = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        redir_v;
   logic [31:0] redir_pc;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_pc;
   logic [31:0] o_inst;
   logic        o_err;

   always #5 clk = ~clk;

   ysyx_24090003_ifu_prefetch_if #(.XLEN(32)) mif ();

   ysyx_24090003_ifu_prefetch dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_redirect_valid (redir_v),
      .i_redirect_pc    (redir_pc),
      .mem              (mif),
      .o_valid          (o_valid),
      .i_ready          (i_ready),
      .o_pc             (o_pc),
      .o_inst           (o_inst),
      .o_err            (o_err)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          acc_total = 0;
   int          resp_total = 0;
   logic [31:0] q_addr[$];
   int          q_cyc[$];
   logic [31:0] acc[$];
   logic [31:0] pops[$];
   logic        pop_err[$];
   bit          rsp_en, mem_ready, idu_ready;
   logic [31:0] err_addr;
   logic        s_ovalid, s_rsp;
   int          pm, am;

   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return a ^ 32'h5A5A_F00F;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, sample 1ns later.
   task automatic step(input bit rv, input logic [31:0] rpc);
      logic [31:0] a;
      @(negedge clk);
      redir_v  = rv;
      redir_pc = rpc;
      i_ready  = idu_ready;
      mif.i_mem_req_ready = mem_ready;
      if (rsp_en && q_addr.size() > 0 && q_cyc[0] < cyc) begin
         a = q_addr.pop_front();
         void'(q_cyc.pop_front());
         mif.i_mem_rsp_valid = 1'b1;
         mif.i_mem_rsp_data  = mem_data(a);
         mif.i_mem_rsp_err   = (a == err_addr);
         resp_total++;
      end else begin
         mif.i_mem_rsp_valid = 1'b0;
         mif.i_mem_rsp_data  = '0;
         mif.i_mem_rsp_err   = 1'b0;
      end
      #1;
      s_rsp    = mif.i_mem_rsp_valid;
      s_ovalid = o_valid;
      if (mif.o_mem_req_valid && mif.i_mem_req_ready) begin
         acc.push_back(mif.o_mem_req_addr);
         q_addr.push_back(mif.o_mem_req_addr);
         q_cyc.push_back(cyc);
         acc_total++;
         check_eq("outstanding_le_max", 32'((acc_total - resp_total) <= c_MAX_OS), 32'd1);
      end
      if (o_valid && i_ready) begin
         pops.push_back(o_pc);
         pop_err.push_back(o_err);
         check_eq("inst_of_pc", o_inst, mem_data(o_pc));
      end
      cyc++;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; redir_v = 1'b0; redir_pc = '0; i_ready = 1'b0;
      mif.i_mem_req_ready = 1'b0; mif.i_mem_rsp_valid = 1'b0;
      mif.i_mem_rsp_data = '0; mif.i_mem_rsp_err = 1'b0;
      rsp_en = 1'b1; mem_ready = 1'b1; idu_ready = 1'b1; err_addr = 32'h1;

      // Reset values
      step(0, '0); step(0, '0);
      check_eq("rst_o_valid", 32'(o_valid), 32'd0);
      check_eq("rst_req_valid", 32'(mif.o_mem_req_valid), 32'd0);
      check_eq("rst_o_pc", o_pc, 32'd0);
      check_eq("rst_o_inst", o_inst, 32'd0);
      check_eq("rst_o_err", 32'(o_err), 32'd0);
      rst = 1'b0;

      // First request right after release, then steady streaming
      step(0, '0);
      check_eq("first_req_valid", 32'(mif.o_mem_req_valid), 32'd1);
      check_eq("first_req_addr", mif.o_mem_req_addr, c_RESET_PC);
      repeat (11) step(0, '0);
      check_eq("stream_pop_count", 32'(pops.size()), 32'd10);

      // IDU stall: queue fills to depth, requests stop
      idu_ready = 1'b0;
      repeat (10) step(0, '0);
      check_eq("stall_no_pop", 32'(pops.size()), 32'd10);
      check_eq("stall_buffered", 32'(acc_total - pops.size()), 32'd4);
      check_eq("stall_o_valid", 32'(o_valid), 32'd1);
      check_eq("stall_no_req", 32'(mif.o_mem_req_valid), 32'd0);
      idu_ready = 1'b1;
      repeat (10) step(0, '0);
      for (int i = 0; i < pops.size(); i++)
         check_eq("seq_pc", pops[i], c_RESET_PC + 32'(4 * i));

      // Redirect with two requests in flight
      rsp_en = 1'b0;
      repeat (6) step(0, '0);
      check_eq("os_before_redirect", 32'(q_addr.size()), 32'd2);
      check_eq("drained_before_redirect", 32'(o_valid), 32'd0);
      step(1, 32'h8000_1002);
      rsp_en = 1'b1;
      pm = pops.size(); am = acc.size();
      repeat (8) step(0, '0);
      check_eq("redir_first_req", (acc.size() > am) ? acc[am] : 32'hDEAD_BEEF, 32'h8000_1000);
      check_eq("redir_first_pop", (pops.size() > pm) ? pops[pm] : 32'hDEAD_BEEF, 32'h8000_1000);
      check_eq("redir_second_pop", (pops.size() > pm + 1) ? pops[pm+1] : 32'hDEAD_BEEF, 32'h8000_1004);

      // Redirect coinciding with a response and a pop
      err_addr = 32'h8000_000C;
      step(1, c_RESET_PC);
      check_eq("t4_pop_at_redirect", 32'(s_ovalid & i_ready), 32'd1);
      check_eq("t4_rsp_at_redirect", 32'(s_rsp), 32'd1);
      for (int i = pm; i < pops.size(); i++)
         check_eq("post_redirect_seq", pops[i], 32'h8000_1000 + 32'(4 * (i - pm)));
      pm = pops.size(); am = acc.size();
      step(0, '0);
      check_eq("t4_flushed", 32'(o_valid), 32'd0);

      // Access fault at 0x8000000C halts issue until redirect
      repeat (10) step(0, '0);
      check_eq("err_pop_count", 32'(pops.size() - pm), 32'd5);
      check_eq("err_acc_count", 32'(acc.size() - am), 32'd5);
      for (int i = 0; i < 5 && (pm + i) < pops.size(); i++) begin
         check_eq("err_seq_pc", pops[pm+i], c_RESET_PC + 32'(4 * i));
         check_eq("err_flag", 32'(pop_err[pm+i]), 32'(i == 3));
      end
      am = acc.size();
      repeat (6) step(0, '0);
      check_eq("halt_no_accept", 32'(acc.size() - am), 32'd0);
      check_eq("halt_no_req", 32'(mif.o_mem_req_valid), 32'd0);
      err_addr = 32'h1;
      step(1, 32'h8000_0100);
      am = acc.size();
      repeat (6) step(0, '0);
      check_eq("resume_req", (acc.size() > am) ? acc[am] : 32'hDEAD_BEEF, 32'h8000_0100);

      // Address wrap at the top of the space
      step(1, 32'hFFFF_FFF8);
      pm = pops.size(); am = acc.size();
      repeat (10) step(0, '0);
      for (int i = 0; i < 4; i++) begin
         check_eq("wrap_req", (acc.size() > am + i) ? acc[am+i] : 32'hDEAD_BEEF, 32'hFFFF_FFF8 + 32'(4 * i));
         check_eq("wrap_pop", (pops.size() > pm + i) ? pops[pm+i] : 32'hDEAD_BEEF, 32'hFFFF_FFF8 + 32'(4 * i));
      end

      // Asynchronous reset in the middle of a burst
      #2;
      rst = 1'b1;
      #1;
      check_eq("async_rst_o_valid", 32'(o_valid), 32'd0);
      check_eq("async_rst_req_valid", 32'(mif.o_mem_req_valid), 32'd0);
      q_addr.delete(); q_cyc.delete();
      acc_total = 0; resp_total = 0;
      mif.i_mem_rsp_valid = 1'b0;
      step(0, '0); step(0, '0);
      rst = 1'b0;
      pm = pops.size();
      step(0, '0);
      check_eq("restart_req_valid", 32'(mif.o_mem_req_valid), 32'd1);
      check_eq("restart_req_addr", mif.o_mem_req_addr, c_RESET_PC);
      repeat (5) step(0, '0);
      check_eq("restart_first_pop", (pops.size() > pm) ? pops[pm] : 32'hDEAD_BEEF, c_RESET_PC);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
